// File: rtl/escaner_teclado_pkg.sv
// Shared FSM state type and default parameter values for the keypad scanner.
package escaner_teclado_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } estado_t;

    localparam int          SCAN_DIV_DEF   = 1000;
    localparam int          DEB_CICLOS_DEF = 50000;
    localparam logic [15:0] TIPO_MASK_DEF  = 16'b0010_0111_0111_0111;

endpackage

// File: rtl/escaner_teclado_sincronizador.sv
// Parametrised-width two-flop synchronizer for asynchronous level inputs.
module sincronizador #(
    parameter int ANCHO = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ANCHO-1:0] d,
    output logic [ANCHO-1:0] q
);

    logic [ANCHO-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/escaner_teclado.sv
// Matrix keypad scanner with debounce; optional auto-repeat via TECLADO_REPEAT_EN.
// state    | meaning
// SCAN     | drive columns in turn, look for a single pressed row
// DEBOUNCE | column held, row pattern must stay stable
// PRESSED  | key accepted and held
// RELEASE  | rows read zero, must stay zero to finish the press
module escaner_teclado
    import escaner_teclado_pkg::*;
#(
    parameter int                    FILAS      = 4,
    parameter int                    COLS       = 4,
    parameter int                    SCAN_DIV   = SCAN_DIV_DEF,
    parameter int                    DEB_CICLOS = DEB_CICLOS_DEF,
    parameter logic [FILAS*COLS-1:0] TIPO_MASK  = TIPO_MASK_DEF
`ifdef TECLADO_REPEAT_EN
    ,
    parameter int                    REP_CICLOS = 25000000
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FILAS-1:0]                fil,
    output logic [COLS-1:0]                 col,
    output logic [$clog2(FILAS*COLS)-1:0]   tecla,
    output logic                            tipo,
    output logic                            valida,
    output logic                            presionada
);

    localparam int TW  = $clog2(FILAS*COLS);
    localparam int RW  = $clog2(FILAS);
    localparam int CIW = $clog2(COLS);
    localparam int CNT_BASE = (SCAN_DIV > DEB_CICLOS) ? SCAN_DIV : DEB_CICLOS;
`ifdef TECLADO_REPEAT_EN
    localparam int CNT_MAX = (REP_CICLOS > CNT_BASE) ? REP_CICLOS : CNT_BASE;
`else
    localparam int CNT_MAX = CNT_BASE;
`endif
    localparam int CW = $clog2(CNT_MAX) + 1;

    estado_t          estado, estado_sig;
    logic [CIW-1:0]   col_idx, col_sig, col_next;
    logic [CW-1:0]    cnt, cnt_sig;
    logic [FILAS-1:0] fs, patron, patron_sig;
    logic [RW-1:0]    fila_idx;
    logic [TW-1:0]    tecla_sig;
    logic             valida_sig, un_bit;

    sincronizador #(.ANCHO(FILAS)) u_sinc (
        .clk (clk),
        .rst (rst),
        .d   (fil),
        .q   (fs)
    );

    assign un_bit     = (fs != '0) && ((fs & (fs - 1'b1)) == '0);
    assign col_next   = (col_idx == CIW'(COLS-1)) ? '0 : col_idx + 1'b1;
    assign presionada = (estado == PRESSED) || (estado == RELEASE);

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            col[COLS-1-c] = (col_idx == CIW'(c));
        end
    end

    // Row index counts from the MSB of fil.
    always_comb begin
        fila_idx = '0;
        for (int i = 0; i < FILAS; i++) begin
            if (patron[i]) fila_idx = RW'(FILAS-1-i);
        end
    end

    assign tecla_sig = TW'(fila_idx * COLS + col_idx);

    always_comb begin
        estado_sig = estado;
        col_sig    = col_idx;
        cnt_sig    = cnt;
        patron_sig = patron;
        valida_sig = 1'b0;
        case (estado)
            SCAN: begin
                if (cnt == CW'(SCAN_DIV-1)) begin
                    cnt_sig = '0;
                    if (un_bit) begin
                        estado_sig = DEBOUNCE;
                        patron_sig = fs;
                    end else begin
                        col_sig = col_next;
                    end
                end else begin
                    cnt_sig = cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (fs != patron) begin
                    estado_sig = SCAN;
                    col_sig    = col_next;
                    cnt_sig    = '0;
                end else if (cnt == CW'(DEB_CICLOS-1)) begin
                    estado_sig = PRESSED;
                    cnt_sig    = '0;
                    valida_sig = 1'b1;
                end else begin
                    cnt_sig = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (fs == '0) begin
                    estado_sig = RELEASE;
                    cnt_sig    = '0;
                end
`ifdef TECLADO_REPEAT_EN
                else if (cnt == CW'(REP_CICLOS-1)) begin
                    cnt_sig    = '0;
                    valida_sig = 1'b1;
                end else begin
                    cnt_sig = cnt + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (fs != '0) begin
                    estado_sig = PRESSED;
                    cnt_sig    = '0;
                end else if (cnt == CW'(DEB_CICLOS-1)) begin
                    estado_sig = SCAN;
                    col_sig    = col_next;
                    cnt_sig    = '0;
                end else begin
                    cnt_sig = cnt + 1'b1;
                end
            end
            default: begin
                estado_sig = SCAN;
                cnt_sig    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= SCAN;
            col_idx <= '0;
            cnt     <= '0;
            patron  <= '0;
            tecla   <= '0;
            tipo    <= 1'b0;
            valida  <= 1'b0;
        end else begin
            estado  <= estado_sig;
            col_idx <= col_sig;
            cnt     <= cnt_sig;
            patron  <= patron_sig;
            valida  <= valida_sig;
            if (valida_sig) begin
                tecla <= tecla_sig;
                tipo  <= TIPO_MASK[tecla_sig];
            end
        end
    end

endmodule
